clk_div_monitor: RTL and testbench

Measures the period and high time of a slow divided clock and reports whether it matches an expected divide ratio. The block is the checking end of the clock-divider path: a divider output, such as the divide-by-3 50%-duty clock, is fed to `mon_in`. The monitor samples it in the `clk` domain, timestamps edges with counters, and raises lock, error and timeout status. Status goes to the control/debug registers.

---
 rtl/clk_div_monitor.sv | 185 ++++++++++++++++++
 tb/tb_clk_div_monitor.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_monitor.sv
// Checks a slow divided clock against an expected period: measures rise-to-rise
// period and high time, and reports lock, sticky error and sticky timeout status.
module clk_div_monitor #(
    parameter int CNT_W      = 8,
    parameter int EXP_PERIOD = 6,
    parameter int TOL        = 0,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mon_in,
    input  logic             err_clr,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             err,
    output logic             timeout
);

    localparam int                GC_W      = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W:0]    EXP_EXT   = (CNT_W + 1)'(EXP_PERIOD);
    localparam logic [CNT_W:0]    TOL_EXT   = (CNT_W + 1)'(TOL);
    localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [GC_W-1:0]   LOCK_C    = GC_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        TRACK
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             s1;
    logic             s2;
    logic             s3;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] pcnt;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] hlat;
    logic [GC_W-1:0]  good_cnt;
    logic [GC_W-1:0]  good_next;
    logic             locked_next;
    logic             clear_cnt;
    logic             do_meas;
    logic             meas_good;
    logic             set_err;
    logic             set_to;
    logic [CNT_W:0]   pcnt_ext;
    logic [CNT_W:0]   diff;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= mon_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    // One extra bit keeps the absolute difference free of wrap-around.
    always_comb begin
        pcnt_ext  = {1'b0, pcnt};
        diff      = (pcnt_ext >= EXP_EXT) ? (pcnt_ext - EXP_EXT) : (EXP_EXT - pcnt_ext);
        meas_good = (diff <= TOL_EXT) && (pcnt != CNT_MAX);
    end

    always_comb begin
        state_next  = state;
        clear_cnt   = 1'b0;
        do_meas     = 1'b0;
        set_err     = 1'b0;
        set_to      = 1'b0;
        good_next   = good_cnt;
        locked_next = locked;
        if (!en) begin
            state_next  = IDLE;
            clear_cnt   = 1'b1;
            good_next   = '0;
            locked_next = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_next  = ACQ;
                    clear_cnt   = 1'b1;
                    good_next   = '0;
                    locked_next = 1'b0;
                end
                ACQ: begin
                    if (rise) begin
                        state_next = TRACK;
                    end else if (pcnt == TIMEOUT_C) begin
                        set_to = 1'b1;
                    end
                end
                TRACK: begin
                    if (rise) begin
                        do_meas = 1'b1;
                        if (meas_good) begin
                            good_next   = (good_cnt == LOCK_C) ? good_cnt : good_cnt + 1'b1;
                            locked_next = (good_next == LOCK_C);
                        end else begin
                            good_next   = '0;
                            locked_next = 1'b0;
                            set_err     = 1'b1;
                        end
                    end else if (pcnt == TIMEOUT_C) begin
                        set_to      = 1'b1;
                        good_next   = '0;
                        locked_next = 1'b0;
                        state_next  = ACQ;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Counters run only while acquiring or tracking; a partial period is dropped on exit.
    always_ff @(posedge clk) begin
        if (rst || clear_cnt) begin
            pcnt <= '0;
            hcnt <= '0;
            hlat <= '0;
        end else begin
            if (rise) begin
                pcnt <= CNT_W'(1);
            end else if (pcnt != CNT_MAX) begin
                pcnt <= pcnt + 1'b1;
            end
            if (rise) begin
                hcnt <= CNT_W'(1);
            end else if (s2 && (hcnt != CNT_MAX)) begin
                hcnt <= hcnt + 1'b1;
            end
            if (fall) begin
                hlat <= hcnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            good_cnt   <= '0;
            locked     <= 1'b0;
            meas_valid <= 1'b0;
            period     <= '0;
            high_time  <= '0;
            err        <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_next;
            good_cnt   <= good_next;
            locked     <= locked_next;
            meas_valid <= do_meas;
            if (do_meas) begin
                period    <= pcnt;
                high_time <= hlat;
            end
            if (set_err) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
            if (set_to) begin
                timeout <= 1'b1;
            end else if (err_clr) begin
                timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Self-checking bench for clk_div_monitor: directed scenarios plus random waveforms,
// compared every cycle against a timestamp-based model of the measurements.
module tb_clk_div_monitor;

    localparam int CNT_W = 8;
    localparam int EXP   = 6;
    localparam int TOL   = 1;
    localparam int LOCKN = 4;
    localparam int TMO   = 64;
    localparam int CMAX  = 255;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             mon_in;
    logic             err_clr;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             err;
    logic             timeout;

    int checks = 0;
    int errors = 0;

    // Model: mode 0 = disabled, 1 = waiting for first rise, 2 = measuring
    int samp[$];
    int edge_n = 0;
    int m_mode = 0;
    int m_origin = 0;
    int m_hl = 0;
    int m_run = 0;
    int m_period = 0;
    int m_high = 0;
    int m_mv = 0;
    int m_locked = 0;
    int m_err = 0;
    int m_to = 0;
    int saved;

    always #5 clk = ~clk;

    clk_div_monitor #(
        .CNT_W(CNT_W),
        .EXP_PERIOD(EXP),
        .TOL(TOL),
        .LOCK_COUNT(LOCKN),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .mon_in(mon_in),
        .err_clr(err_clr),
        .period(period),
        .high_time(high_time),
        .meas_valid(meas_valid),
        .locked(locked),
        .err(err),
        .timeout(timeout)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    // Events are derived from the history of mon_in as seen by the clock; a rise
    // observed two edges ago is acted on at this edge. Periods are edge differences.
    task automatic modelStep();
        int  pc;
        int  dv;
        bit  rise_e;
        bit  fall_e;
        bit  set_e;
        bit  set_t;
        edge_n++;
        samp.push_back((rst || (mon_in !== 1'b1)) ? 0 : 1);
        void'(samp.pop_front());
        rise_e = (samp[1] == 1) && (samp[0] == 0);
        fall_e = (samp[1] == 0) && (samp[0] == 1);
        if (rst) begin
            m_mode = 0; m_period = 0; m_high = 0; m_mv = 0; m_locked = 0;
            m_err = 0; m_to = 0; m_run = 0; m_hl = 0;
            return;
        end
        m_mv = 0;
        set_e = 0;
        set_t = 0;
        if (!en) begin
            m_mode = 0; m_locked = 0; m_run = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
            m_origin = edge_n + 1;
        end else begin
            pc = edge_n - m_origin;
            if (pc > CMAX) pc = CMAX;
            if (fall_e) m_hl = pc;
            if (m_mode == 1) begin
                if (rise_e) begin
                    m_mode = 2;
                    m_origin = edge_n;
                end else if (pc == TMO) begin
                    set_t = 1;
                end
            end else if (rise_e) begin
                m_period = pc;
                m_high = m_hl;
                m_mv = 1;
                m_origin = edge_n;
                dv = (pc > EXP) ? pc - EXP : EXP - pc;
                if (dv <= TOL && pc != CMAX) begin
                    m_run++;
                end else begin
                    m_run = 0;
                    set_e = 1;
                end
                m_locked = (m_run >= LOCKN) ? 1 : 0;
            end else if (pc == TMO) begin
                set_t = 1; m_run = 0; m_locked = 0; m_mode = 1;
            end
        end
        if (set_e) m_err = 1;
        else if (err_clr) m_err = 0;
        if (set_t) m_to = 1;
        else if (err_clr) m_to = 0;
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic m, input logic c);
        rst = r;
        en = e;
        mon_in = m;
        err_clr = c;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput("period", period, m_period);
        checkOutput("high_time", high_time, m_high);
        checkOutput("meas_valid", meas_valid, m_mv);
        checkOutput("locked", locked, m_locked);
        checkOutput("err", err, m_err);
        checkOutput("timeout", timeout, m_to);
    endtask

    task automatic runWave(input int hi, input int lo, input int n);
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < hi; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
            for (int i = 0; i < lo; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic randomPhase(input int nseg);
        int hi;
        int lo;
        int sel;
        logic en_v;
        for (int k = 0; k < nseg; k++) begin
            sel = $urandom_range(0, 99);
            hi = (sel < 50) ? 3 : $urandom_range(2, 6);
            lo = (sel < 50) ? $urandom_range(2, 4) : $urandom_range(2, 6);
            if (sel >= 95) lo = $urandom_range(60, 75);
            en_v = !(sel >= 90 && sel < 93);
            for (int i = 0; i < hi + lo; i++) begin
                applyStimulus(($urandom_range(0, 399) == 0), en_v, (i < hi),
                              ($urandom_range(0, 99) < 3));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        mon_in = 1'b0;
        err_clr = 1'b0;
        samp = '{0, 0, 0, 0};

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_period", period, 0);
        checkOutput("reset_locked", locked, 0);

        $display("[TB] ideal clk/6");
        runWave(3, 3, 8);
        checkOutput("ideal_locked", locked, 1);
        checkOutput("ideal_period", period, 6);
        checkOutput("ideal_high", high_time, 3);
        checkOutput("ideal_err", err, 0);

        $display("[TB] single bad period");
        runWave(3, 6, 1);
        runWave(3, 3, 6);
        checkOutput("bad_err_sticky", err, 1);
        checkOutput("bad_relock", locked, 1);

        $display("[TB] stuck input");
        runWave(0, 75, 1);
        checkOutput("stuck_timeout", timeout, 1);
        checkOutput("stuck_locked", locked, 0);

        $display("[TB] flag clear");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("clr_err", err, 0);
        checkOutput("clr_timeout", timeout, 0);
        runWave(3, 3, 7);
        checkOutput("restart_locked", locked, 1);

        $display("[TB] clear coinciding with bad measurement");
        runWave(3, 6, 1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, (i < 3), (i == 2));
            if (i == 1) checkOutput("clr_pre_err", err, 0);
            if (i == 2) checkOutput("clr_vs_set_err", err, 1);
        end

        $display("[TB] tolerance band");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        for (int p = 0; p < 6; p++) begin
            runWave(3, 2, 1);
            runWave(3, 4, 1);
        end
        checkOutput("band_err", err, 0);
        checkOutput("band_locked", locked, 1);

        $display("[TB] reset and enable mid-operation");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("midrst_period", period, 0);
        checkOutput("midrst_locked", locked, 0);
        runWave(3, 3, 8);
        saved = m_period;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, ((i % 6) < 3), 1'b0);
            checkOutput("en_off_mv", meas_valid, 0);
            checkOutput("en_off_locked", locked, 0);
            checkOutput("en_off_period", period, saved);
        end
        runWave(3, 3, 7);
        checkOutput("en_back_locked", locked, 1);

        $display("[TB] random waveforms");
        randomPhase(250);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
